// File: rtl/elastic_pipe_chain.sv
// Chain of DEPTH elastic stages, each a 2-entry skid buffer (main + skid), with
// per-stage flush, global hold and a registered occupancy count.
module elastic_pipe_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(2*DEPTH+1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    input  logic [DEPTH-1:0]   flush_mask,
    input  logic               hold,
    output logic [CNT_W-1:0]   occupancy,
    output logic               empty
);

    localparam int CW1 = CNT_W + 1;

    logic [DEPTH-1:0]  r_mainValid;
    logic [DEPTH-1:0]  r_skidValid;
    logic [WIDTH-1:0]  r_mainData [DEPTH];
    logic [WIDTH-1:0]  r_skidData [DEPTH];
    logic [CNT_W-1:0]  r_occupancy;

    logic [DEPTH:0]    w_srcValid;
    logic [WIDTH-1:0]  w_srcData [DEPTH+1];
    logic [DEPTH:0]    w_accept;
    logic [DEPTH-1:0]  w_mainValidNext;
    logic [DEPTH-1:0]  w_skidValidNext;
    logic [WIDTH-1:0]  w_mainDataNext [DEPTH];
    logic [WIDTH-1:0]  w_skidDataNext [DEPTH];
    logic [CW1-1:0]    w_killed;
    logic [CW1-1:0]    w_occNext;

    assign in_ready  = reset & ~hold & ~r_skidValid[0];
    assign out_valid = reset & ~hold & r_mainValid[DEPTH-1];
    assign out_data  = reset ? r_mainData[DEPTH-1] : '0;
    assign occupancy = r_occupancy;
    assign empty     = (r_occupancy == '0);

    // Slot 0 is the input port, slot i+1 is stage i's main register; w_accept[DEPTH] is the output handshake.
    always_comb begin
        w_srcValid   = {r_mainValid, in_valid};
        w_srcData[0] = in_data;
        for (int i = 0; i < DEPTH; i++) begin
            w_srcData[i+1] = r_mainData[i];
            w_accept[i]    = ~hold & w_srcValid[i] & ~r_skidValid[i];
        end
        w_accept[DEPTH] = out_valid & out_ready;
    end

    always_comb begin
        w_mainValidNext = r_mainValid;
        w_skidValidNext = r_skidValid;
        w_killed        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_mainDataNext[i] = r_mainData[i];
            w_skidDataNext[i] = r_skidData[i];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (w_accept[i+1]) begin
                if (r_skidValid[i]) begin
                    w_mainDataNext[i]  = r_skidData[i];
                    w_skidValidNext[i] = 1'b0;
                end else begin
                    w_mainValidNext[i] = 1'b0;
                end
            end
            if (w_accept[i]) begin
                if (!w_mainValidNext[i]) begin
                    w_mainDataNext[i]  = w_srcData[i];
                    w_mainValidNext[i] = 1'b1;
                end else begin
                    w_skidDataNext[i]  = w_srcData[i];
                    w_skidValidNext[i] = 1'b1;
                end
            end
            // A flush kills whatever would be resident after this edge, including an arriving entry.
            if (!hold && flush_mask[i]) begin
                w_killed = w_killed + CW1'(w_mainValidNext[i]) + CW1'(w_skidValidNext[i]);
                w_mainValidNext[i] = 1'b0;
                w_skidValidNext[i] = 1'b0;
            end
        end
        w_occNext = CW1'(r_occupancy) + CW1'(w_accept[0]) - CW1'(w_accept[DEPTH]) - w_killed;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mainValid <= '0;
            r_skidValid <= '0;
            r_occupancy <= '0;
        end else begin
            r_mainValid <= w_mainValidNext;
            r_skidValid <= w_skidValidNext;
            r_occupancy <= w_occNext[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        r_mainData <= w_mainDataNext;
        r_skidData <= w_skidDataNext;
    end

    occupancyInRange: assert property (@(posedge clk) disable iff (!reset)
        w_occNext <= CW1'(2*DEPTH));

endmodule
